// File: rtl/counter_sequencer.sv
// Command-driven sequencer for the tile's external up-counter: load, count to limit, optional reload passes.
// Optional build macro CNTSEQ_PAUSE_TIMEOUT_EN aborts a PAUSE that lasts 256 cycles with an err pulse.
module counter_sequencer #(
  parameter int WIDTH    = 8,
  parameter int REPEAT_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [WIDTH-1:0]    cfg_start,
  input  logic [WIDTH-1:0]    cfg_limit,
  input  logic [REPEAT_W-1:0] cfg_repeat,
  input  logic [WIDTH-1:0]    cnt_val,
  output logic                cnt_load,
  output logic [WIDTH-1:0]    cnt_load_val,
  output logic                cnt_en,
  output logic                busy,
  output logic                paused,
  output logic [REPEAT_W-1:0] runs_left,
  output logic                done,
  output logic                err
);

  localparam logic [1:0] OP_START  = 2'b00;
  localparam logic [1:0] OP_STOP   = 2'b01;
  localparam logic [1:0] OP_RESUME = 2'b10;
  localparam logic [1:0] OP_ABORT  = 2'b11;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, PAUSE} state_t;

  state_t              state, next_state;
  logic [WIDTH-1:0]    start_q, limit_q;
  logic [REPEAT_W-1:0] rep_left, rep_next;
  logic                accept, terminal, timeout;
  logic                is_start, is_stop, is_resume, is_abort;
  logic                done_next, err_next, latch_cfg;

  assign accept    = cmd_valid && cmd_ready;
  assign is_start  = (cmd_op == OP_START);
  assign is_stop   = (cmd_op == OP_STOP);
  assign is_resume = (cmd_op == OP_RESUME);
  assign is_abort  = (cmd_op == OP_ABORT);
  assign terminal  = (cnt_val == limit_q);

`ifdef CNTSEQ_PAUSE_TIMEOUT_EN
  logic [7:0] pause_timer;

  // Timer sits at zero outside PAUSE, so the first PAUSE cycle always sees 0.
  always_ff @(posedge clk) begin
    if (!rst_n || state != PAUSE) pause_timer <= 8'd0;
    else                          pause_timer <= pause_timer + 8'd1;
  end

  assign timeout = (state == PAUSE) && (pause_timer == 8'hFF);
`else
  assign timeout = 1'b0;
`endif

  // State register and registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      start_q   <= '0;
      limit_q   <= '0;
      rep_left  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      paused    <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state     <= next_state;
      rep_left  <= rep_next;
      done      <= done_next;
      err       <= err_next;
      busy      <= (next_state != IDLE);
      paused    <= (next_state == PAUSE);
      cmd_ready <= (next_state != LOAD);
      if (latch_cfg) begin
        start_q <= cfg_start;
        limit_q <= cfg_limit;
      end
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    rep_next   = rep_left;
    done_next  = 1'b0;
    err_next   = 1'b0;
    latch_cfg  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (is_start) begin
            next_state = LOAD;
            latch_cfg  = 1'b1;
            rep_next   = cfg_repeat;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      LOAD: next_state = RUN;
      RUN: begin
        if (accept && is_abort) begin
          next_state = IDLE;
        end else if (terminal && rep_left == '0) begin
          // Completion beats any other command on the last terminal cycle.
          next_state = IDLE;
          done_next  = 1'b1;
          err_next   = accept;
        end else begin
          if (terminal) rep_next = rep_left - 1'b1;
          if (accept && is_stop) next_state = PAUSE;
          else if (accept)       err_next   = 1'b1;
        end
      end
      PAUSE: begin
        if (accept && is_resume) begin
          next_state = RUN;
        end else if (accept && is_abort) begin
          next_state = IDLE;
        end else begin
          err_next = accept;
          if (timeout) begin
            next_state = IDLE;
            err_next   = 1'b1;
          end
        end
      end
    endcase
  end

  // Counter controls
  always_comb begin
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    unique case (state)
      LOAD: cnt_load = 1'b1;
      RUN: begin
        cnt_en   = !terminal;
        cnt_load = terminal && (rep_left != '0) && !(accept && is_abort);
      end
      default: ;
    endcase
  end

  assign cnt_load_val = start_q;
  assign runs_left    = rep_left;

  a_load_en_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(cnt_load && cnt_en));
  a_done_not_busy:     assert property (@(posedge clk) disable iff (!rst_n) done |-> !busy);
  a_paused_busy:       assert property (@(posedge clk) disable iff (!rst_n) paused |-> busy);

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: vector table, directed corner sequences and
// randomized commands against a distance-based model of the counter sequence.
module tb_counter_sequencer;
  localparam int WIDTH = 8;
  localparam int REPEAT_W = 4;
  localparam logic [1:0] OP_START = 2'b00, OP_STOP = 2'b01, OP_RESUME = 2'b10, OP_ABORT = 2'b11;
`ifdef CNTSEQ_PAUSE_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [WIDTH-1:0] cfg_start = '0, cfg_limit = '0;
  logic [REPEAT_W-1:0] cfg_repeat = '0;
  logic [WIDTH-1:0] cnt_val = '0;
  logic cmd_ready, cnt_load, cnt_en, busy, paused, done, err;
  logic [WIDTH-1:0] cnt_load_val;
  logic [REPEAT_W-1:0] runs_left;

  int checks = 0;
  int errors = 0;

  counter_sequencer #(.WIDTH(WIDTH), .REPEAT_W(REPEAT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cfg_start(cfg_start), .cfg_limit(cfg_limit), .cfg_repeat(cfg_repeat), .cnt_val(cnt_val),
    .cnt_load(cnt_load), .cnt_load_val(cnt_load_val), .cnt_en(cnt_en), .busy(busy),
    .paused(paused), .runs_left(runs_left), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // The tile's counter register
  always @(posedge clk) begin
    if (cnt_load)    cnt_val <= cnt_load_val;
    else if (cnt_en) cnt_val <= cnt_val + 8'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: a sequence is a start value plus a step count along a pass of known length.
  bit m_busy, m_load, m_pause, m_done, m_err;
  int m_steps, m_dist, m_rep, m_ptime;
  logic [7:0] m_S;

  task automatic model_reset();
    m_busy = 0; m_load = 0; m_pause = 0; m_done = 0; m_err = 0;
    m_steps = 0; m_dist = 0; m_rep = 0; m_ptime = 0; m_S = '0;
  endtask

  task automatic model_edge(input bit acc, input logic [1:0] op, input logic [7:0] s,
                            input logic [7:0] l, input logic [3:0] r, input bit term);
    m_done = 0; m_err = 0;
    if (!m_busy) begin
      if (acc && op == OP_START) begin
        m_S = s; m_dist = int'(8'(l - s)); m_rep = int'(r);
        m_busy = 1; m_load = 1;
      end else if (acc) m_err = 1;
    end else if (m_load) begin
      m_load = 0; m_steps = 0;
    end else if (m_pause) begin
      if (acc && op == OP_RESUME) m_pause = 0;
      else if (acc && op == OP_ABORT) begin m_busy = 0; m_pause = 0; end
      else begin
        if (acc) m_err = 1;
        if (TIMEOUT_EN && m_ptime == 255) begin m_busy = 0; m_pause = 0; m_err = 1; end
        else m_ptime++;
      end
    end else if (acc && op == OP_ABORT) begin
      m_busy = 0;
    end else if (term && m_rep == 0) begin
      m_busy = 0; m_done = 1; m_err = acc;
    end else begin
      if (term) begin m_rep--; m_steps = 0; end
      else m_steps++;
      if (acc && op == OP_STOP) begin m_pause = 1; m_ptime = 0; end
      else if (acc) m_err = 1;
    end
  endtask

  // One clock cycle: drive at edge+1, check combinational controls, then registered state after the edge.
  task automatic step(input bit v, input logic [1:0] op, input logic [7:0] s = 8'd0,
                      input logic [7:0] l = 8'd0, input logic [3:0] r = 4'd0);
    bit acc, term, e_en, e_load;
    cmd_valid = v; cmd_op = op; cfg_start = s; cfg_limit = l; cfg_repeat = r;
    #1;
    acc    = v && !m_load;
    term   = m_busy && !m_load && !m_pause && (m_steps == m_dist);
    e_en   = m_busy && !m_load && !m_pause && !term;
    e_load = m_load || (term && m_rep > 0 && !(acc && op == OP_ABORT));
    check("cmd_ready", cmd_ready, !m_load);
    check("cnt_en", cnt_en, e_en);
    check("cnt_load", cnt_load, e_load);
    if (e_load) check("cnt_load_val", cnt_load_val, m_S);
    model_edge(acc, op, s, l, r, term);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("busy", busy, m_busy);
    check("paused", paused, m_pause);
    check("runs_left", runs_left, m_rep);
    check("done", done, m_done);
    check("err", err, m_err);
    if (m_busy && !m_load) check("cnt_val", cnt_val, (int'(m_S) + m_steps) % 256);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic run_until_cnt(input logic [7:0] t, input string name);
    int n = 0;
    while (cnt_val !== t && n < 300) begin step(1'b0, OP_START); n++; end
    check({name, " reached"}, cnt_val, t);
  endtask

  task automatic run_until_done(input string name, output int cycles, output logic [7:0] last_cnt,
                                output int ens, output int reloads);
    cycles = 0; ens = 0; reloads = 0; last_cnt = cnt_val;
    while (cycles < 300) begin
      last_cnt = cnt_val;
      if (cnt_en) ens++;
      if (cnt_load) reloads++;
      step(1'b0, OP_START);
      cycles++;
      if (done) break;
    end
    check({name, " done"}, done, 1);
  endtask

  typedef struct {
    bit v; logic [1:0] op; logic [7:0] s, l; logic [3:0] r;
    bit e_load, e_en, e_busy, e_done, e_err, chk; logic [7:0] e_cnt;
  } vec_t;

  function automatic vec_t mkv(int v, int op, int s, int l, int r, int el, int ee,
                               int eb, int ed, int er, int chk, int ec);
    vec_t t;
    t.v = 1'(v); t.op = 2'(op); t.s = 8'(s); t.l = 8'(l); t.r = 4'(r);
    t.e_load = 1'(el); t.e_en = 1'(ee); t.e_busy = 1'(eb); t.e_done = 1'(ed);
    t.e_err = 1'(er); t.chk = 1'(chk); t.e_cnt = 8'(ec);
    return t;
  endfunction

  vec_t tbl[9];

  initial begin
    int cyc, ens, rel;
    logic [7:0] last;

    do_reset();
    check("rst busy", busy, 0);
    check("rst paused", paused, 0);
    check("rst runs_left", runs_left, 0);
    check("rst done", done, 0);
    check("rst err", err, 0);
    check("rst cmd_ready", cmd_ready, 1);
    check("rst cnt_en", cnt_en, 0);
    check("rst cnt_load", cnt_load, 0);
    check("rst cnt_load_val", cnt_load_val, 0);

    // Illegal RESUME in IDLE, then S=3 L=7 single pass
    tbl[0] = mkv(1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[1] = mkv(1, 0, 3, 7, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[2] = mkv(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 3);
    tbl[3] = mkv(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 4);
    tbl[4] = mkv(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 5);
    tbl[5] = mkv(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 6);
    tbl[6] = mkv(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 7);
    tbl[7] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[8] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    foreach (tbl[i]) begin
      cmd_valid = tbl[i].v; cmd_op = tbl[i].op; cfg_start = tbl[i].s;
      cfg_limit = tbl[i].l; cfg_repeat = tbl[i].r;
      #1;
      check($sformatf("vec%0d cnt_load", i), cnt_load, tbl[i].e_load);
      check($sformatf("vec%0d cnt_en", i), cnt_en, tbl[i].e_en);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check($sformatf("vec%0d busy", i), busy, tbl[i].e_busy);
      check($sformatf("vec%0d done", i), done, tbl[i].e_done);
      check($sformatf("vec%0d err", i), err, tbl[i].e_err);
      if (tbl[i].chk) check($sformatf("vec%0d cnt_val", i), cnt_val, tbl[i].e_cnt);
    end
    do_reset();

    // Wrapping pass with one reload
    step(1'b1, OP_START, 8'd250, 8'd2, 4'd1);
    step(1'b0, OP_START);
    run_until_done("wrap", cyc, last, ens, rel);
    check("wrap run cycles", cyc, 18);
    check("wrap en plus reload cycles", ens + rel, 17);
    check("wrap reloads", rel, 1);
    check("wrap last cnt", last, 2);
    step(1'b0, OP_START);
    check("wrap single done", done, 0);

    // Pause mid-run: STOP in the cnt_val==4 cycle freezes the counter at 5
    step(1'b1, OP_START, 8'd0, 8'd9, 4'd0);
    step(1'b0, OP_START);
    run_until_cnt(8'd4, "stop");
    step(1'b1, OP_STOP);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, OP_START);
      check("pause hold cnt", cnt_val, 5);
    end
    check("pause paused", paused, 1);
    step(1'b1, OP_RESUME);
    run_until_done("resume", cyc, last, ens, rel);
    check("resume last cnt", last, 9);

    // Illegal START while running leaves the sequence intact
    step(1'b1, OP_START, 8'd10, 8'd14, 4'd0);
    step(1'b0, OP_START);
    step(1'b0, OP_START);
    step(1'b1, OP_START, 8'd99, 8'd99, 4'd3);
    check("run start err", err, 1);
    check("run start busy", busy, 1);
    run_until_done("run start", cyc, last, ens, rel);
    check("run start last cnt", last, 14);

    // Terminal collisions
    step(1'b1, OP_START, 8'd0, 8'd4, 4'd0);
    step(1'b0, OP_START);
    run_until_cnt(8'd4, "abort");
    step(1'b1, OP_ABORT);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort err", err, 0);
    step(1'b1, OP_START, 8'd0, 8'd4, 4'd0);
    step(1'b0, OP_START);
    run_until_cnt(8'd4, "stopterm");
    step(1'b1, OP_STOP);
    check("stopterm done", done, 1);
    check("stopterm err", err, 1);
    check("stopterm busy", busy, 0);

    // Reset mid-run
    step(1'b1, OP_START, 8'd0, 8'd200, 4'd5);
    step(1'b0, OP_START);
    repeat (3) step(1'b0, OP_START);
    do_reset();
    check("midrst busy", busy, 0);
    check("midrst cnt_en", cnt_en, 0);
    check("midrst runs_left", runs_left, 0);
    check("midrst done", done, 0);
    step(1'b0, OP_START);

    if (TIMEOUT_EN) begin
      step(1'b1, OP_START, 8'd0, 8'd100, 4'd0);
      step(1'b0, OP_START);
      repeat (2) step(1'b0, OP_START);
      step(1'b1, OP_STOP);
      repeat (255) step(1'b0, OP_START);
      check("timeout still paused", paused, 1);
      step(1'b0, OP_START);
      check("timeout busy", busy, 0);
      check("timeout err", err, 1);
      check("timeout done", done, 0);
    end

    // Randomized commands against the model
    for (int n = 0; n < 1500; n++) begin
      logic [7:0] rs;
      rs = 8'($urandom);
      step($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), rs,
           rs + 8'($urandom_range(0, 6)), 4'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
